// File: rtl/seq_gen_multi_if.sv
// Control/status bundle for seq_gen_multi: step controls in, sequence code and strobe out.
// wrap_cnt exists only when SEQ_WRAP_CNT_EN is defined.
interface seq_gen_multi_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic [1:0]       mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] state;
  logic             tc;
`ifdef SEQ_WRAP_CNT_EN
  logic [7:0]       wrap_cnt;
`endif

  modport master (
    output en, mode, dir, load, load_val,
`ifdef SEQ_WRAP_CNT_EN
    input  wrap_cnt,
`endif
    input  state, tc
  );

  modport slave (
    input  en, mode, dir, load, load_val,
`ifdef SEQ_WRAP_CNT_EN
    output wrap_cnt,
`endif
    output state, tc
  );
endinterface

// File: rtl/seq_gen_multi.sv
// Multi-mode sequence generator (binary/Gray/Johnson/LFSR); SEQ_WRAP_CNT_EN adds a saturating wrap counter.
// Latency: state updates one clk edge after load/en sampled high; tc is combinational.
// Backpressure: none; en gates stepping, load overrides en.
module seq_gen_multi #(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(3'b110)
) (
  input  logic           clk,
  input  logic           rst,
  seq_gen_multi_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_BIN  = 2'd0,
    MODE_GRAY = 2'd1,
    MODE_JOHN = 2'd2,
    MODE_LFSR = 2'd3
  } mode_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] GRAY_TOP = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // A Johnson code has at most one transition between adjacent bits.
  function automatic logic johnson_ok(input logic [WIDTH-1:0] s);
    int unsigned n;
    n = 0;
    for (int i = 0; i < WIDTH-1; i++) begin
      n = n + 32'(s[i] ^ s[i+1]);
    end
    return n <= 1;
  endfunction

  mode_t            mode;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] origin;
  logic [WIDTH-1:0] gbin;

  assign mode = mode_t'(bus.mode);

  always_comb begin
    nxt    = '0;
    origin = '0;
    gbin   = gray2bin(state_q);
    unique case (mode)
      MODE_BIN: begin
        nxt    = bus.dir ? state_q + ONE : state_q - ONE;
        origin = bus.dir ? '0 : ONES;
      end
      MODE_GRAY: begin
        nxt    = bus.dir ? bin2gray(gbin + ONE) : bin2gray(gbin - ONE);
        origin = bus.dir ? '0 : GRAY_TOP;
      end
      MODE_JOHN: begin
        nxt    = johnson_ok(state_q) ? {state_q[WIDTH-2:0], ~state_q[WIDTH-1]} : '0;
        origin = '0;
      end
      MODE_LFSR: begin
        nxt    = (state_q == '0) ? ONE : {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        origin = ONE;
      end
    endcase
  end

  assign bus.tc    = bus.en & ~bus.load & rst & (nxt == origin);
  assign bus.state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
    end else if (bus.load) begin
      state_q <= bus.load_val;
    end else if (bus.en) begin
      state_q <= nxt;
    end
  end

`ifdef SEQ_WRAP_CNT_EN
  logic [7:0] wrap_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= '0;
    end else if (bus.load) begin
      wrap_q <= '0;
    end else if (bus.tc && wrap_q != 8'hFF) begin
      wrap_q <= wrap_q + 8'd1;
    end
  end

  assign bus.wrap_cnt = wrap_q;
`endif

endmodule

// File: tb/tb_seq_gen_multi.sv
// Directed bench for seq_gen_multi (WIDTH=3, TAPS=110) with a per-cycle reference model.
module tb_seq_gen_multi;

  logic clk;
  logic rst;
  int   vecs  = 0;
  int   fails = 0;

  localparam logic [2:0] TAPS = 3'b110;

  seq_gen_multi_if #(.WIDTH(3)) bus ();
  seq_gen_multi #(.WIDTH(3), .TAPS(TAPS)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef SEQ_WRAP_CNT_EN
  seq_gen_multi_if #(.WIDTH(2)) bus2 ();
  seq_gen_multi #(.WIDTH(2), .TAPS(2'b11)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected sequences written out by hand.
  logic [2:0] gup   [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  logic [2:0] jseq  [7] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
  logic [2:0] lseq  [8] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001};
  logic [2:0] jcodes[6] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100};

  // Reference model: successor and origin derived from the sequence definitions.
  function automatic logic [2:0] m_next(input logic [2:0] s, input logic [1:0] md, input logic d);
    int v;
    int idx;
    v = 0;
    case (md)
      2'd0: v = d ? int'(s) + 1 : int'(s) - 1;
      2'd1: begin
        for (int k = 0; k < 3; k++) v = v ^ (int'(s) >> k);
        v = (d ? v + 1 : v - 1) & 7;
        v = v ^ (v >> 1);
      end
      2'd2: begin
        idx = -1;
        for (int k = 0; k < 6; k++) if (jcodes[k] == s) idx = k;
        v = (idx < 0) ? 0 : int'(jcodes[(idx + 1) % 6]);
      end
      default: v = (s == 3'd0) ? 1 : ((int'(s) << 1) | ($countones(s & TAPS) & 1));
    endcase
    return v[2:0];
  endfunction

  function automatic logic [2:0] m_origin(input logic [1:0] md, input logic d);
    case (md)
      2'd0:    return d ? 3'd0 : 3'd7;
      2'd1:    return d ? 3'd0 : 3'd4;
      2'd2:    return 3'd0;
      default: return 3'd1;
    endcase
  endfunction

  logic [2:0] m_state;
  int         m_wrap;

  function automatic logic m_tc(input logic [2:0] s);
    return bus.en && !bus.load && rst && (m_next(s, bus.mode, bus.dir) == m_origin(bus.mode, bus.dir));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= 3'd0;
      m_wrap  <= 0;
    end else if (bus.load) begin
      m_state <= bus.load_val;
      m_wrap  <= 0;
    end else if (bus.en) begin
      if (m_tc(m_state) && m_wrap < 255) m_wrap <= m_wrap + 1;
      m_state <= m_next(m_state, bus.mode, bus.dir);
    end
  end

  always @(negedge clk) begin
    vecs++;
    if (bus.state !== m_state) begin
      fails++;
      $display("FAIL model_state t=%0t: got %0d want %0d", $time, bus.state, m_state);
    end
    vecs++;
    if (bus.tc !== m_tc(m_state)) begin
      fails++;
      $display("FAIL model_tc t=%0t: got %0b want %0b", $time, bus.tc, m_tc(m_state));
    end
`ifdef SEQ_WRAP_CNT_EN
    vecs++;
    if (int'(bus.wrap_cnt) != m_wrap) begin
      fails++;
      $display("FAIL model_wrap t=%0t: got %0d want %0d", $time, bus.wrap_cnt, m_wrap);
    end
`endif
  end

  task automatic chk(input string nm, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic look(input string nm, input logic [2:0] es, input logic et);
    #1;
    chk({nm, "_state"}, int'(bus.state), int'(es));
    chk({nm, "_tc"}, int'(bus.tc), int'(et));
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    bus.en = 1'b0; bus.mode = 2'd0; bus.dir = 1'b1; bus.load = 1'b0; bus.load_val = 3'd0;
`ifdef SEQ_WRAP_CNT_EN
    bus2.en = 1'b1; bus2.mode = 2'd0; bus2.dir = 1'b1; bus2.load = 1'b0; bus2.load_val = 2'd0;
`endif
    repeat (2) cyc();
    look("reset", 3'd0, 1'b0);
`ifdef SEQ_WRAP_CNT_EN
    chk("wrap_reset", int'(bus2.wrap_cnt), 0);
`endif

    // Binary up from reset, then async reset mid-count.
    rst = 1'b1; bus.en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      look("bin_up", 3'(i % 8), (i % 8) == 7);
      cyc();
    end
    repeat (4) cyc();
    look("bin_at5", 3'd5, 1'b0);
    rst = 1'b0;
    look("rst_async", 3'd0, 1'b0);
    cyc();
    rst = 1'b1;
    look("after_rst", 3'd0, 1'b0);
    cyc();
    look("first_step", 3'd1, 1'b0);

    // Binary down wraps 0 -> 7 with tc at 0.
    bus.dir = 1'b0;
    look("bin_dn1", 3'd1, 1'b0);
    cyc();
    look("bin_dn0", 3'd0, 1'b1);
    cyc();
    look("bin_dn7", 3'd7, 1'b0);

    // Gray up, then down from 011.
    bus.mode = 2'd1; bus.dir = 1'b1; bus.load = 1'b1; bus.load_val = 3'd0;
    cyc();
    bus.load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      look("gray_up", gup[i], i == 7);
      cyc();
    end
    cyc();
    bus.dir = 1'b0;
    look("gray_dn011", 3'b011, 1'b0);
    cyc();
    look("gray_dn001", 3'b001, 1'b0);
    cyc();
    look("gray_dn000", 3'b000, 1'b1);
    cyc();
    look("gray_dn100", 3'b100, 1'b0);

    // Johnson, then illegal-state recovery.
    bus.mode = 2'd2; bus.load = 1'b1; bus.load_val = 3'd0;
    look("john_load_tc", 3'b100, 1'b0);
    cyc();
    bus.load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      look("john", jseq[i], i == 5);
      cyc();
    end
    bus.load = 1'b1; bus.load_val = 3'b010;
    cyc();
    bus.load = 1'b0;
    look("john_illegal", 3'b010, 1'b1);
    cyc();
    look("john_recover", 3'b000, 1'b0);

    // LFSR from lock-up state.
    bus.mode = 2'd3; bus.load = 1'b1; bus.load_val = 3'd0;
    cyc();
    bus.load = 1'b0;
    look("lfsr_lock", 3'd0, 1'b1);
    cyc();
    for (int i = 0; i < 8; i++) begin
      look("lfsr", lseq[i], i == 6);
      cyc();
    end
    bus.load = 1'b1; bus.load_val = 3'd0;
    cyc();
    bus.load = 1'b0;
    look("lfsr_reload0", 3'd0, 1'b1);
    cyc();
    look("lfsr_unlock", 3'd1, 1'b0);

    // Load beats enable; disabled hold.
    bus.mode = 2'd0; bus.dir = 1'b1; bus.en = 1'b1; bus.load = 1'b1; bus.load_val = 3'd6;
    look("prio_tc", 3'd1, 1'b0);
    cyc();
    bus.load = 1'b0; bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      look("hold", 3'd6, 1'b0);
      cyc();
    end

`ifdef SEQ_WRAP_CNT_EN
    repeat (1100) cyc();
    chk("wrap_sat", int'(bus2.wrap_cnt), 255);
    bus2.load = 1'b1;
    cyc();
    bus2.load = 1'b0;
    #1;
    chk("wrap_clear", int'(bus2.wrap_cnt), 0);
`endif

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
